// File: rtl/seg7_scan.sv
// Multiplexed 7-segment display scanner with anti-ghosting blank, PWM brightness and leading-zero blanking.
// Optional hex decode of nibbles 10-15 when SEG7_HEX_EN is defined.
module seg7_scan #(
    parameter int NUM_DIGITS     = 4,
    parameter int DIV            = 6750,
    parameter int BLANK_CYCLES   = 64,
    parameter int SEG_ACTIVE_LOW = 1,
    parameter int DIG_ACTIVE_LOW = 1
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [4*NUM_DIGITS-1:0]   digits_i,
    input  logic [NUM_DIGITS-1:0]     dp_i,
    input  logic                      lzb_en,
    input  logic [3:0]                brightness,
    output logic [6:0]                seg,
    output logic                      dp,
    output logic [NUM_DIGITS-1:0]     dig,
    output logic                      frame_tick
);

    localparam int CNT_W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int SEL_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam logic [31:0] SPAN  = 32'(DIV - BLANK_CYCLES);
    localparam logic [31:0] BLANK = 32'(BLANK_CYCLES);
    localparam logic SEG_INV = (SEG_ACTIVE_LOW != 0);
    localparam logic DIG_INV = (DIG_ACTIVE_LOW != 0);
    localparam logic [6:0] SEG_OFF = {7{SEG_INV}};
    localparam logic [NUM_DIGITS-1:0] DIG_OFF = {NUM_DIGITS{DIG_INV}};

    function automatic logic [6:0] decode(input logic [3:0] n);
        logic [6:0] p;
        case (n)
            4'd0: p = 7'b0111111;
            4'd1: p = 7'b0000110;
            4'd2: p = 7'b1011011;
            4'd3: p = 7'b1001111;
            4'd4: p = 7'b1100110;
            4'd5: p = 7'b1101101;
            4'd6: p = 7'b1111101;
            4'd7: p = 7'b0000111;
            4'd8: p = 7'b1111111;
            4'd9: p = 7'b1101111;
`ifdef SEG7_HEX_EN
            4'd10: p = 7'b1110111;
            4'd11: p = 7'b1111100;
            4'd12: p = 7'b0111001;
            4'd13: p = 7'b1011110;
            4'd14: p = 7'b1111001;
            4'd15: p = 7'b1110001;
`endif
            default: p = 7'b0000000;
        endcase
        return p;
    endfunction

    logic [CNT_W-1:0]        cnt;
    logic [SEL_W-1:0]        sel;
    logic                    first;
    logic [4*NUM_DIGITS-1:0] sh_digits;
    logic [NUM_DIGITS-1:0]   sh_dp;
    logic                    sh_lzb;
    logic [3:0]              sh_bright;

    logic                    slot_end;
    logic                    frame_end;
    logic [31:0]             on_len;
    logic                    lit;
    logic [3:0]              nib;
    logic                    cur_dp;
    logic                    zeros_above;
    logic                    blank_lz;
    logic [6:0]              seg_on;
    logic [NUM_DIGITS-1:0]   dig_on;

    assign slot_end  = (cnt == CNT_W'(DIV - 1));
    assign frame_end = slot_end && (sel == '0);
    // Full 32-bit product so brightness 15 reaches exactly the end of the slot.
    assign on_len    = (SPAN * (32'(sh_bright) + 32'd1)) >> 4;
    assign lit       = (32'(cnt) >= BLANK) && (32'(cnt) < BLANK + on_len);

    always_comb begin
        nib         = 4'd0;
        cur_dp      = 1'b0;
        zeros_above = 1'b1;
        blank_lz    = 1'b0;
        dig_on      = '0;
        // Walk from the most significant digit so zeros_above covers digit k and all above it.
        for (int k = NUM_DIGITS - 1; k >= 0; k--) begin
            zeros_above = zeros_above && (sh_digits[4*k +: 4] == 4'd0);
            if (sel == SEL_W'(k)) begin
                nib       = sh_digits[4*k +: 4];
                cur_dp    = sh_dp[k];
                blank_lz  = sh_lzb && zeros_above && (k != 0);
                dig_on[k] = 1'b1;
            end
        end
        seg_on = blank_lz ? 7'b0000000 : decode(nib);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt        <= '0;
            sel        <= SEL_W'(NUM_DIGITS - 1);
            first      <= 1'b1;
            sh_digits  <= '0;
            sh_dp      <= '0;
            sh_lzb     <= 1'b0;
            sh_bright  <= 4'd0;
            frame_tick <= 1'b0;
            seg        <= SEG_OFF;
            dp         <= SEG_INV;
            dig        <= DIG_OFF;
        end else begin
            first <= 1'b0;
            if (slot_end) begin
                cnt <= '0;
                sel <= (sel == '0) ? SEL_W'(NUM_DIGITS - 1) : sel - SEL_W'(1);
            end else begin
                cnt <= cnt + CNT_W'(1);
            end
            // Shadows only move at a frame boundary, so a frame never shows mixed inputs.
            if (first || frame_end) begin
                sh_digits <= digits_i;
                sh_dp     <= dp_i;
                sh_lzb    <= lzb_en;
                sh_bright <= brightness;
            end
            frame_tick <= frame_end;
            seg        <= lit ? (seg_on ^ SEG_OFF) : SEG_OFF;
            dp         <= lit ? (cur_dp ^ SEG_INV) : SEG_INV;
            dig        <= lit ? (dig_on ^ DIG_OFF) : DIG_OFF;
        end
    end

endmodule

// File: tb/tb_seg7_scan.sv
// Self-checking bench for seg7_scan: time-based reference model compared every cycle,
// plus directed per-frame measurements with hand-computed expectations.
module tb_seg7_scan;

    localparam int N    = 4;
    localparam int DIV  = 100;
    localparam int B    = 20;
    localparam int F    = N * DIV;
    localparam int SPAN = DIV - B;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [15:0] digits_i = 16'h1234;
    logic [3:0]  dp_i = 4'b0000;
    logic        lzb_en = 1'b0;
    logic [3:0]  brightness = 4'd15;
    logic [6:0]  seg;
    logic        dp;
    logic [3:0]  dig;
    logic        frame_tick;

    int tests = 0;
    int fails = 0;

    seg7_scan #(
        .NUM_DIGITS(N), .DIV(DIV), .BLANK_CYCLES(B),
        .SEG_ACTIVE_LOW(1), .DIG_ACTIVE_LOW(1)
    ) dut (
        .clk(clk), .rst_n(rst_n), .digits_i(digits_i), .dp_i(dp_i),
        .lzb_en(lzb_en), .brightness(brightness), .seg(seg), .dp(dp),
        .dig(dig), .frame_tick(frame_tick)
    );

    always #5 clk = ~clk;

    function automatic logic [6:0] pat(input logic [3:0] n);
        logic [6:0] p;
        case (n)
            4'd0: p = 7'b0111111;  4'd1: p = 7'b0000110;
            4'd2: p = 7'b1011011;  4'd3: p = 7'b1001111;
            4'd4: p = 7'b1100110;  4'd5: p = 7'b1101101;
            4'd6: p = 7'b1111101;  4'd7: p = 7'b0000111;
            4'd8: p = 7'b1111111;  4'd9: p = 7'b1101111;
`ifdef SEG7_HEX_EN
            4'd10: p = 7'b1110111; 4'd11: p = 7'b1111100;
            4'd12: p = 7'b0111001; 4'd13: p = 7'b1011110;
            4'd14: p = 7'b1111001; 4'd15: p = 7'b1110001;
`endif
            default: p = 7'b0000000;
        endcase
        return p;
    endfunction

    // Reference model: position in the scan is derived purely from elapsed clocks since reset release.
    int          ecount;
    logic [15:0] m_dig;
    logic [3:0]  m_dp;
    logic        m_lzb;
    logic [3:0]  m_br;
    logic [6:0]  e_seg = 7'h7F;
    logic        e_dp = 1'b1;
    logic [3:0]  e_dig = 4'hF;
    logic        e_ft = 1'b0;

    always @(posedge clk or negedge rst_n) begin : model
        int phase, digit, on;
        logic lit, allz;
        if (!rst_n) begin
            ecount = 0;
            m_dig = '0; m_dp = '0; m_lzb = 1'b0; m_br = '0;
            e_seg = 7'h7F; e_dp = 1'b1; e_dig = 4'hF; e_ft = 1'b0;
        end else begin
            phase = ecount % DIV;
            digit = N - 1 - ((ecount / DIV) % N);
            on    = (SPAN * (int'(m_br) + 1)) >> 4;
            lit   = (phase >= B) && (phase < B + on);
            allz  = 1'b1;
            for (int k = N - 1; k >= digit; k--)
                if (m_dig[4*k +: 4] != 4'd0) allz = 1'b0;
            e_ft = ((ecount % F) == F - 1);
            if (lit) begin
                e_dig = ~(4'b0001 << digit);
                e_seg = (m_lzb && allz && digit != 0) ? 7'h7F : ~pat(m_dig[4*digit +: 4]);
                e_dp  = ~m_dp[digit];
            end else begin
                e_dig = 4'hF; e_seg = 7'h7F; e_dp = 1'b1;
            end
            if (ecount == 0 || (ecount % F) == F - 1) begin
                m_dig = digits_i; m_dp = dp_i; m_lzb = lzb_en; m_br = brightness;
            end
            ecount++;
        end
    end

    always @(negedge clk) begin
        tests++;
        if ({seg, dp, dig, frame_tick} !== {e_seg, e_dp, e_dig, e_ft}) begin
            fails++;
            $display("FAIL cycle_compare t=%0t seg=%b/%b dp=%b/%b dig=%b/%b tick=%b/%b (actual/required)",
                     $time, seg, e_seg, dp, e_dp, dig, e_dig, frame_tick, e_ft);
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic wait_tick();
        logic got;
        got = 1'b0;
        for (int i = 0; i < 2 * F; i++) begin
            @(negedge clk);
            if (frame_tick === 1'b1) begin
                got = 1'b1;
                break;
            end
        end
        chk("frame_tick_seen", int'(got), 1);
    endtask

    int         lit_cnt[N];
    logic [6:0] seg_at[N];
    logic       dp_at[N];
    int         order[$];
    int         ticks;
    int         tick_pos;

    // Observe exactly one frame, starting at the negedge after a frame_tick.
    task automatic measure(input int change_at, input logic [15:0] new_digits);
        logic [3:0] oh;
        for (int k = 0; k < N; k++) begin
            lit_cnt[k] = 0; seg_at[k] = 7'h7F; dp_at[k] = 1'b1;
        end
        order.delete();
        ticks = 0; tick_pos = -1;
        for (int c = 0; c < F; c++) begin
            @(negedge clk);
            if (c == change_at) digits_i = new_digits;
            if (frame_tick) begin ticks++; tick_pos = c; end
            for (int k = 0; k < N; k++) begin
                oh = ~(4'b0001 << k);
                if (dig === oh) begin
                    if (lit_cnt[k] == 0) order.push_back(k);
                    lit_cnt[k]++;
                    seg_at[k] = seg;
                    dp_at[k]  = dp;
                end
            end
        end
    endtask

    initial begin
        int n;
        logic found;
        #12;
        chk("reset_seg", int'(seg), 'h7F);
        chk("reset_dp", int'(dp), 1);
        chk("reset_dig", int'(dig), 'hF);
        chk("reset_tick", int'(frame_tick), 0);
        @(negedge clk);
        rst_n = 1'b1;

        wait_tick();
        measure(-1, 16'h0);
        chk("order_size", order.size(), 4);
        if (order.size() == 4) begin
            chk("order0", order[0], 3); chk("order1", order[1], 2);
            chk("order2", order[2], 1); chk("order3", order[3], 0);
        end
        for (int k = 0; k < N; k++) chk("lit_b15", lit_cnt[k], 80);
        chk("seg_d3_1", int'(seg_at[3]), 'b1111001);
        chk("seg_d2_2", int'(seg_at[2]), 'b0100100);
        chk("seg_d1_3", int'(seg_at[1]), 'b0110000);
        chk("seg_d0_4", int'(seg_at[0]), 'b0011001);
        chk("ticks_per_frame", ticks, 1);
        chk("tick_pos", tick_pos, F - 1);

        measure(150, 16'h5678);
        chk("midframe_d3_old", int'(seg_at[3]), 'b1111001);
        chk("midframe_d0_old", int'(seg_at[0]), 'b0011001);
        measure(-1, 16'h0);
        chk("next_frame_d3_5", int'(seg_at[3]), 'b0010010);
        chk("next_frame_d0_8", int'(seg_at[0]), 'b0000000);
        chk("tick_pos2", tick_pos, F - 1);

        brightness = 4'd0;
        wait_tick();
        measure(-1, 16'h0);
        chk("lit_b0", lit_cnt[2], 5);
        brightness = 4'd7;
        wait_tick();
        measure(-1, 16'h0);
        chk("lit_b7", lit_cnt[1], 40);

        brightness = 4'd15; digits_i = 16'h0007; lzb_en = 1'b1; dp_i = 4'b0100;
        wait_tick();
        measure(-1, 16'h0007);
        chk("lzb_d3_seg", int'(seg_at[3]), 'h7F);
        chk("lzb_d2_seg", int'(seg_at[2]), 'h7F);
        chk("lzb_d2_dp", int'(dp_at[2]), 0);
        chk("lzb_d1_seg", int'(seg_at[1]), 'h7F);
        chk("lzb_d0_seg7", int'(seg_at[0]), 'b1111000);
        chk("lzb_d0_dp", int'(dp_at[0]), 1);
        chk("lzb_d2_lit", lit_cnt[2], 80);

        digits_i = 16'h123A; lzb_en = 1'b0; dp_i = 4'b0000;
        wait_tick();
        measure(-1, 16'h123A);
`ifdef SEG7_HEX_EN
        chk("hex_A", int'(seg_at[0]), 'b0001000);
`else
        chk("hex_A_blank", int'(seg_at[0]), 'h7F);
`endif

        found = 1'b0;
        for (int i = 0; i < 2 * DIV; i++) begin
            @(negedge clk);
            if (dig !== 4'hF) begin found = 1'b1; break; end
        end
        chk("lit_before_reset", int'(found), 1);
        #1 rst_n = 1'b0;
        #1;
        chk("async_rst_seg", int'(seg), 'h7F);
        chk("async_rst_dp", int'(dp), 1);
        chk("async_rst_dig", int'(dig), 'hF);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        n = 0; found = 1'b0;
        for (int i = 0; i < 2 * DIV; i++) begin
            @(negedge clk);
            n++;
            if (dig !== 4'hF) begin found = 1'b1; break; end
        end
        chk("resume_found", int'(found), 1);
        chk("resume_latency", n, B + 1);
        chk("resume_digit3", int'(dig), 'b0111);

        repeat (10) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
